dataflow_stall_watchdog: RTL and testbench
==========================================

# dataflow_stall_watchdog

Run-time controller that sits beside the `myproject` dataflow region in co-simulation and debug builds. It consumes the per-process idle, channel-block and AXI-stream-block vectors. It qualifies a global stop condition over a programmable window, then snapshots the blocking processes and issues a one-shot report through a valid/ready handshake. It then holds a `halt` request to the harness until software clears it.

## Interface
Parameters:
- `N_PROC`, 13: number of dataflow processes monitored.
- `IDX_W`, 4: width of the process index; must satisfy 2^IDX_W >= N_PROC.
- `WIN_W`, 16: width of the qualification-window register.
- `CNT_W`, 32: width of the stop-cycle statistics counter.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: arms the watchdog.
- `clear` in 1: single-cycle pulse; releases `HALTED` and zeroes statistics.
- `window` in WIN_W: number of consecutive stop cycles required; a value of 0 is treated as 1.
- `proc_idle` in N_PROC: per-process idle.
- `proc_chan_block` in N_PROC: per-process FIFO/channel blocked.
- `proc_axis_block` in N_PROC: per-process AXI-stream blocked.
- `report_valid` out 1: report available.
- `report_ready` in 1: consumer accepts the report.
- `report_code` out 2: 2'b01 = AXI-stream stall, 2'b10 = channel-only deadlock.
- `report_idx` out IDX_W: lowest-indexed blocked process.
- `report_mask` out N_PROC: snapshot of `proc_chan_block | proc_axis_block`.
- `halt` out 1: stop request to the harness.
- `stop_cycles` out CNT_W: saturating count of sampled stop cycles.
- `state` out 2: current FSM state, for debug.

## Operation
- Per-process terms: `stopped[i] = idle | chan_block | axis_block`; `blocked[i] = chan_block | axis_block`.
- Stop condition: `stop = &stopped & |blocked`. All-idle is not a stall.
- `W_eff = (window == 0) ? 1 : window`.
- FSM states and encodings:
  - `DISABLED` (0):
    - On `enable`, go to `WATCH`.
  - `WATCH` (1):
    - `run` = 0.
    - On a sampled `stop`: if `W_eff == 1`, go to `REPORT`; otherwise `run` = 1 and stay in `WATCH`.
  - Qualification while in `WATCH`:
    - Each edge with `stop` increments `run`.
    - The edge on which `run + 1 == W_eff` moves the FSM to `REPORT`.
    - Any edge without `stop` zeroes `run`.
  - `REPORT` (2):
    - On `report_valid & report_ready`, go to `HALTED`.
  - `HALTED` (3):
    - On `clear`, go to `WATCH` with `run` = 0.
- Entry into `REPORT` latches the following from the inputs sampled on that same edge; they stay stable until the handshake:
  - `report_mask` = `blocked`.
  - `report_idx` = lowest i with `blocked[i]`.
  - `report_code` = 2'b01 if `|proc_axis_block`, else 2'b10.
- `report_valid` = 1 exactly in `REPORT`.
- `halt` = 1 exactly in `HALTED`.
- `enable` = 0:
  - From `WATCH`: go to `DISABLED` next edge and zero `run`.
  - `REPORT` and `HALTED` ignore `enable`.
- `clear`:
  - Zeroes `stop_cycles` in any state.
  - Is ignored for FSM purposes outside `HALTED`.
  - If `clear` coincides with the handshake in `REPORT`, the handshake wins: go to `HALTED`.
- `stop_cycles`:
  - Increments on every edge with `stop` while the state is not `DISABLED`.
  - Saturates at all-ones.
  - `clear` takes priority over the increment.
- `run` saturates at `W_eff`.
- Re-arming after a `window` change:
  - A `window` change while `run > 0` takes effect immediately.
  - If the new `W_eff <= run`, the next `stop` edge goes to `REPORT`.

## Timing
- Reset values:
  - `state` = `DISABLED`, `run` = 0.
  - `report_valid` = 0, `report_code` = 0, `report_idx` = 0, `report_mask` = 0.
  - `halt` = 0, `stop_cycles` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: with `stop` sampled on edges t .. t+W_eff-1, `report_valid` is high after edge t+W_eff-1.
- A report is held for an unbounded number of cycles while `report_ready` = 0.
- `report_valid` drops and `halt` rises after the accepting edge.
- `halt` drops after the edge that samples `clear`.
- Reset asserted mid-`REPORT` or mid-`HALTED` returns every output to its reset value on that edge; no report is replayed.

## Test plan
- N_PROC=13, window=4, all idle for 100 cycles -> `report_valid` never rises; `stop_cycles` stays 0.
- Window=4; `proc_chan_block[5]`=1 with all others idle for 4 cycles -> `report_valid` high after the 4th edge; `report_code`=2'b10, `report_idx`=5, `report_mask`=0x0020.
- Window=4; stop held 3 cycles, dropped 1 cycle, then held 4 cycles -> single report after the final edge of the 4-cycle run; `stop_cycles`=7.
- Window=0; `proc_axis_block[12]` and `proc_chan_block[8]` set, others idle -> report after the first edge; `report_code`=2'b01, `report_idx`=8, `report_mask`=0x1100.
- Report pending with `report_ready`=0 for 10 cycles and `enable` dropped -> fields stable and still in `REPORT`; `ready` pulse -> `halt`=1; `clear` -> `halt`=0, state `WATCH` (`enable`=1) or `DISABLED` next edge (`enable`=0).
- Reset asserted in `HALTED` -> next cycle all outputs at reset values and state `DISABLED`.

Source files
------------

// File: rtl/dataflow_stall_watchdog_if.sv
// Report channel between the stall watchdog and its consumer.
//   report_valid : report available (watchdog -> consumer)
//   report_ready : consumer accepts the report (consumer -> watchdog)
//   report_code  : 2'b01 AXI-stream stall, 2'b10 channel-only deadlock
//   report_idx   : lowest-indexed blocked process
//   report_mask  : snapshot of the per-process blocked vector
interface dataflow_stall_watchdog_if #(
  parameter int N_PROC = 13,
  parameter int IDX_W  = 4
);
  logic              report_valid;
  logic              report_ready;
  logic [1:0]        report_code;
  logic [IDX_W-1:0]  report_idx;
  logic [N_PROC-1:0] report_mask;

  modport master (
    output report_valid,
    output report_code,
    output report_idx,
    output report_mask,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_code,
    input  report_idx,
    input  report_mask,
    output report_ready
  );
endinterface

// File: rtl/dataflow_stall_watchdog.sv
// Dataflow stall watchdog. Watches per-process idle / channel-block /
// AXI-stream-block vectors, qualifies a global stop over a programmable
// window, issues one report over a valid/ready channel and then holds
// halt until software pulses clear.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   enable              : arms the watchdog
//   clear               : pulse; releases HALTED and zeroes stop_cycles
//   window              : consecutive stop cycles required (0 acts as 1)
//   proc_idle/_chan_block/_axis_block : per-process status vectors
//   rpt (master)        : report handshake and latched report fields
//   halt                : stop request to the harness
//   stop_cycles         : saturating count of sampled stop cycles
//   state               : current FSM state, for debug
module dataflow_stall_watchdog #(
  parameter int N_PROC = 13,
  parameter int IDX_W  = 4,
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [WIN_W-1:0]          window,
  input  logic [N_PROC-1:0]         proc_idle,
  input  logic [N_PROC-1:0]         proc_chan_block,
  input  logic [N_PROC-1:0]         proc_axis_block,
  dataflow_stall_watchdog_if.master rpt,
  output logic                      halt,
  output logic [CNT_W-1:0]          stop_cycles,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WATCH    = 2'd1,
    REPORT   = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [WIN_W-1:0]  run_r, run_s;
  logic [N_PROC-1:0] blocked_s;
  logic              stop_s;
  logic [WIN_W:0]    w_eff_s;
  logic [WIN_W:0]    run_inc_s;

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_PROC-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Global stop term and effective window (one bit wider so run+1 never wraps).
  always_comb begin
    blocked_s = proc_chan_block | proc_axis_block;
    stop_s    = (&(proc_idle | blocked_s)) & (|blocked_s);
    if (window == {WIN_W{1'b0}}) begin
      w_eff_s = {{WIN_W{1'b0}}, 1'b1};
    end else begin
      w_eff_s = {1'b0, window};
    end
    run_inc_s = {1'b0, run_r} + {{WIN_W{1'b0}}, 1'b1};
  end

  // Next-state and qualification counter. A run that already meets a
  // freshly lowered window reports on the next stop edge via the >= compare.
  always_comb begin
    state_s = state_r;
    run_s   = run_r;
    case (state_r)
      DISABLED: begin
        run_s = '0;
        if (enable) state_s = WATCH;
        else        state_s = DISABLED;
      end
      WATCH: begin
        if (!enable) begin
          state_s = DISABLED;
          run_s   = '0;
        end else if (stop_s) begin
          if (run_inc_s >= w_eff_s) begin
            state_s = REPORT;
            run_s   = '0;
          end else begin
            run_s   = run_inc_s[WIN_W-1:0];
          end
        end else begin
          run_s = '0;
        end
      end
      REPORT: begin
        // report_valid is 1 throughout REPORT, so ready alone completes it;
        // a coincident clear has no effect here.
        run_s = '0;
        if (rpt.report_ready) state_s = HALTED;
        else                  state_s = REPORT;
      end
      HALTED: begin
        run_s = '0;
        if (clear) state_s = WATCH;
        else       state_s = HALTED;
      end
      default: begin
        state_s = DISABLED;
        run_s   = '0;
      end
    endcase
  end

  // State, registered outputs, report snapshot and stop statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= DISABLED;
      run_r            <= '0;
      rpt.report_valid <= 1'b0;
      rpt.report_code  <= 2'b00;
      rpt.report_idx   <= '0;
      rpt.report_mask  <= '0;
      halt             <= 1'b0;
      stop_cycles      <= '0;
    end else begin
      state_r          <= state_s;
      run_r            <= run_s;
      rpt.report_valid <= (state_s == REPORT);
      halt             <= (state_s == HALTED);
      if ((state_r != REPORT) && (state_s == REPORT)) begin
        rpt.report_mask <= blocked_s;
        rpt.report_idx  <= lowest_set(blocked_s);
        rpt.report_code <= (|proc_axis_block) ? 2'b01 : 2'b10;
      end
      if (clear) begin
        stop_cycles <= '0;
      end else if ((state_r != DISABLED) && stop_s && (stop_cycles != {CNT_W{1'b1}})) begin
        stop_cycles <= stop_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_dataflow_stall_watchdog.sv
// Self-checking bench for dataflow_stall_watchdog: directed scenarios with
// constant expectations, then randomized traffic against a cycle model.
module tb_dataflow_stall_watchdog;

  localparam int N_PROC = 13;
  localparam int IDX_W  = 4;
  localparam int WIN_W  = 16;
  localparam int CNT_W  = 32;

  logic              clock = 1'b0;
  logic              reset, enable, clear;
  logic [WIN_W-1:0]  window;
  logic [N_PROC-1:0] proc_idle, proc_chan_block, proc_axis_block;
  logic              halt;
  logic [CNT_W-1:0]  stop_cycles;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int                m_state = 0;
  int                m_run   = 0;
  bit                m_valid = 0;
  bit                m_halt  = 0;
  bit [1:0]          m_code  = 0;
  int                m_idx   = 0;
  bit [N_PROC-1:0]   m_mask  = 0;
  longint unsigned   m_cycles = 0;

  dataflow_stall_watchdog_if #(.N_PROC(N_PROC), .IDX_W(IDX_W)) rpt_bus ();

  dataflow_stall_watchdog #(
    .N_PROC(N_PROC), .IDX_W(IDX_W), .WIN_W(WIN_W), .CNT_W(CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clear          (clear),
    .window         (window),
    .proc_idle      (proc_idle),
    .proc_chan_block(proc_chan_block),
    .proc_axis_block(proc_axis_block),
    .rpt            (rpt_bus.master),
    .halt           (halt),
    .stop_cycles    (stop_cycles),
    .state          (state)
  );

  always #5 clock = ~clock;

  // One clock edge of the behavioural model, from the inputs just sampled.
  function automatic void model_edge();
    int weff;
    bit all_stopped, any_blocked;
    int first;
    bit stop;
    if (reset) begin
      m_state = 0; m_run = 0; m_valid = 0; m_halt = 0;
      m_code = 0; m_idx = 0; m_mask = 0; m_cycles = 0;
      return;
    end
    weff = (window == 0) ? 1 : int'(window);
    all_stopped = 1; any_blocked = 0; first = -1;
    for (int i = 0; i < N_PROC; i++) begin
      if (proc_chan_block[i] || proc_axis_block[i]) begin
        any_blocked = 1;
        if (first < 0) first = i;
      end else if (!proc_idle[i]) begin
        all_stopped = 0;
      end
    end
    stop = all_stopped && any_blocked;
    if (clear) m_cycles = 0;
    else if (m_state != 0 && stop && m_cycles < 64'hFFFF_FFFF) m_cycles++;
    case (m_state)
      0: if (enable) begin m_state = 1; m_run = 0; end
      1: begin
        if (!enable) begin
          m_state = 0; m_run = 0;
        end else if (stop) begin
          if (m_run + 1 >= weff) begin
            m_state = 2; m_run = 0;
            m_mask = proc_chan_block | proc_axis_block;
            m_idx  = first;
            m_code = (proc_axis_block != 0) ? 2'b01 : 2'b10;
          end else begin
            m_run++;
          end
        end else begin
          m_run = 0;
        end
      end
      2: if (rpt_bus.report_ready) m_state = 3;
      3: if (clear) begin m_state = 1; m_run = 0; end
      default: m_state = 0;
    endcase
    m_valid = (m_state == 2);
    m_halt  = (m_state == 3);
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_procs(input logic [N_PROC-1:0] idle, input logic [N_PROC-1:0] chan,
                           input logic [N_PROC-1:0] axis);
    proc_idle = idle; proc_chan_block = chan; proc_axis_block = axis;
  endtask

  // Accept a pending report and clear the halt (stimulus only).
  task automatic drain_report();
    set_procs({N_PROC{1'b1}}, '0, '0);
    rpt_bus.report_ready = 1'b1; tick();
    rpt_bus.report_ready = 1'b0;
    clear = 1'b1; tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; window = 16'd4;
    rpt_bus.report_ready = 1'b0;
    set_procs('0, '0, '0);
    tick(); tick();
    checks++;
    if (state !== 2'd0 || rpt_bus.report_valid !== 1'b0 || halt !== 1'b0 ||
        stop_cycles !== 32'd0 || rpt_bus.report_code !== 2'b00 ||
        rpt_bus.report_idx !== 4'd0 || rpt_bus.report_mask !== 13'd0) begin
      errors++;
      $display("FAIL reset_values: state=%0d valid=%b halt=%b cycles=%0d code=%b idx=%0d mask=%h, required all zero",
               state, rpt_bus.report_valid, halt, stop_cycles, rpt_bus.report_code,
               rpt_bus.report_idx, rpt_bus.report_mask);
    end
    reset = 1'b0;
  endtask

  task automatic test_all_idle();
    bit seen = 0;
    enable = 1'b1; window = 16'd4;
    set_procs({N_PROC{1'b1}}, '0, '0);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rpt_bus.report_valid !== 1'b0 || stop_cycles !== 32'd0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL all_idle: valid or stop_cycles became nonzero, required 0 throughout");
    end
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL idle_state: got %0d required 1", state);
    end
  endtask

  task automatic test_chan_deadlock();
    set_procs(13'h1FDF, 13'h0020, 13'h0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (rpt_bus.report_valid !== (k == 4)) begin
        errors++;
        $display("FAIL chan_latency edge %0d: valid=%b required %b", k, rpt_bus.report_valid, (k == 4));
      end
    end
    checks++;
    if (rpt_bus.report_code !== 2'b10 || rpt_bus.report_idx !== 4'd5 ||
        rpt_bus.report_mask !== 13'h0020 || stop_cycles !== 32'd4) begin
      errors++;
      $display("FAIL chan_fields: code=%b idx=%0d mask=%h cycles=%0d required 10 5 0020 4",
               rpt_bus.report_code, rpt_bus.report_idx, rpt_bus.report_mask, stop_cycles);
    end
    set_procs({N_PROC{1'b1}}, '0, '0);
    rpt_bus.report_ready = 1'b1; tick();
    rpt_bus.report_ready = 1'b0;
    checks++;
    if (halt !== 1'b1 || rpt_bus.report_valid !== 1'b0 || state !== 2'd3) begin
      errors++;
      $display("FAIL chan_accept: halt=%b valid=%b state=%0d required 1 0 3", halt, rpt_bus.report_valid, state);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (halt !== 1'b0 || state !== 2'd1 || stop_cycles !== 32'd0) begin
      errors++;
      $display("FAIL chan_clear: halt=%b state=%0d cycles=%0d required 0 1 0", halt, state, stop_cycles);
    end
  endtask

  task automatic test_broken_run();
    window = 16'd4;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) set_procs({N_PROC{1'b1}}, '0, '0);
      else        set_procs(13'h1FF7, 13'h0008, 13'h0000);
      tick();
      checks++;
      if (rpt_bus.report_valid !== (k == 7)) begin
        errors++;
        $display("FAIL broken_run edge %0d: valid=%b required %b", k, rpt_bus.report_valid, (k == 7));
      end
    end
    checks++;
    if (stop_cycles !== 32'd7) begin
      errors++;
      $display("FAIL broken_run_cycles: got %0d required 7", stop_cycles);
    end
    drain_report();
  endtask

  task automatic test_window0();
    window = 16'd0;
    set_procs(13'h0EFF, 13'h0100, 13'h1000);
    tick();
    checks++;
    if (rpt_bus.report_valid !== 1'b1 || rpt_bus.report_code !== 2'b01 ||
        rpt_bus.report_idx !== 4'd8 || rpt_bus.report_mask !== 13'h1100) begin
      errors++;
      $display("FAIL window0: valid=%b code=%b idx=%0d mask=%h required 1 01 8 1100",
               rpt_bus.report_valid, rpt_bus.report_code, rpt_bus.report_idx, rpt_bus.report_mask);
    end
  endtask

  // Continues from the pending report left by test_window0.
  task automatic test_hold();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_procs(N_PROC'($urandom), N_PROC'($urandom), N_PROC'($urandom));
      tick();
      checks++;
      if (state !== 2'd2 || rpt_bus.report_valid !== 1'b1 || rpt_bus.report_code !== 2'b01 ||
          rpt_bus.report_idx !== 4'd8 || rpt_bus.report_mask !== 13'h1100) begin
        errors++;
        $display("FAIL hold cycle %0d: state=%0d valid=%b code=%b idx=%0d mask=%h required 2 1 01 8 1100",
                 k, state, rpt_bus.report_valid, rpt_bus.report_code, rpt_bus.report_idx, rpt_bus.report_mask);
      end
    end
    set_procs({N_PROC{1'b1}}, '0, '0);
    rpt_bus.report_ready = 1'b1; tick(); rpt_bus.report_ready = 1'b0;
    checks++;
    if (halt !== 1'b1 || rpt_bus.report_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept: halt=%b valid=%b required 1 0", halt, rpt_bus.report_valid);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (halt !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL hold_clear: halt=%b state=%0d required 0 1", halt, state);
    end
    tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL hold_disable: state=%0d required 0", state);
    end
    enable = 1'b1; tick();
  endtask

  task automatic test_reset_in_halted();
    window = 16'd1;
    set_procs(13'h1FFE, 13'h0001, 13'h0000);
    tick();
    rpt_bus.report_ready = 1'b1; tick(); rpt_bus.report_ready = 1'b0;
    checks++;
    if (halt !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_halt: got %b required 1", halt);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (state !== 2'd0 || halt !== 1'b0 || rpt_bus.report_valid !== 1'b0 ||
        stop_cycles !== 32'd0 || rpt_bus.report_code !== 2'b00 ||
        rpt_bus.report_idx !== 4'd0 || rpt_bus.report_mask !== 13'd0) begin
      errors++;
      $display("FAIL reset_in_halted: state=%0d halt=%b valid=%b cycles=%0d code=%b idx=%0d mask=%h required all zero",
               state, halt, rpt_bus.report_valid, stop_cycles, rpt_bus.report_code,
               rpt_bus.report_idx, rpt_bus.report_mask);
    end
  endtask

  task automatic test_random();
    logic [N_PROC-1:0] idle, chan, axis;
    int sel;
    for (int k = 0; k < 3000; k++) begin
      reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 29) == 0);
      rpt_bus.report_ready = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) window = WIN_W'($urandom_range(0, 5));
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        for (int i = 0; i < N_PROC; i++) begin
          case ($urandom_range(0, 5))
            0: begin idle[i] = 1'b0; chan[i] = 1'b1; axis[i] = 1'b0; end
            1: begin idle[i] = 1'b0; chan[i] = 1'b0; axis[i] = 1'b1; end
            2: begin idle[i] = 1'b1; chan[i] = 1'b1; axis[i] = 1'b0; end
            default: begin idle[i] = 1'b1; chan[i] = 1'b0; axis[i] = 1'b0; end
          endcase
        end
      end else if (sel < 8) begin
        idle = {N_PROC{1'b1}}; chan = '0; axis = '0;
      end else begin
        idle = N_PROC'($urandom); chan = N_PROC'($urandom); axis = N_PROC'($urandom);
      end
      set_procs(idle, chan, axis);
      tick();
      checks++;
      if (state !== 2'(m_state) || rpt_bus.report_valid !== m_valid || halt !== m_halt) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: state=%0d valid=%b halt=%b required %0d %b %b",
                 k, state, rpt_bus.report_valid, halt, m_state, m_valid, m_halt);
      end
      checks++;
      if (rpt_bus.report_code !== m_code || rpt_bus.report_idx !== IDX_W'(m_idx) ||
          rpt_bus.report_mask !== m_mask) begin
        errors++;
        $display("FAIL rand_fields cycle %0d: code=%b idx=%0d mask=%h required %b %0d %h",
                 k, rpt_bus.report_code, rpt_bus.report_idx, rpt_bus.report_mask, m_code, m_idx, m_mask);
      end
      checks++;
      if (stop_cycles !== CNT_W'(m_cycles)) begin
        errors++;
        $display("FAIL rand_cycles cycle %0d: got %0d required %0d", k, stop_cycles, m_cycles);
      end
    end
    reset = 1'b0; clear = 1'b0; rpt_bus.report_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_idle();
    test_chan_deadlock();
    test_broken_run();
    test_window0();
    test_hold();
    test_reset_in_halted();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
